// File: rtl/rv_pkg.sv
// Shared types for the instruction-fetch buffer: entry states and default depth.
package rv_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_READY   = 2'd2
    } entry_state_e;

    localparam int RV_IFB_DEPTH = 4;

endpackage

// File: rtl/rv_ifetch_buf.sv
// Instruction-fetch buffer: tracks outstanding bus reads in a circular queue
// and hands completed instructions to decode in request order.
module rv_ifetch_buf
    import rv_pkg::*;
#(
    parameter int DEPTH = RV_IFB_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic [31:2] i_req_pc,
    output logic        o_req_ready,
    output logic        o_mem_req_valid,
    output logic [31:2] o_mem_addr,
    input  logic        i_mem_req_ready,
    input  logic        i_mem_resp_valid,
    input  logic [31:0] i_mem_resp_data,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:2] o_instr_pc,
    input  logic        i_instr_ready,
    input  logic        i_flush
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_state_e  state_reg [DEPTH];
    logic [31:2]   pc_reg    [DEPTH];
    logic [31:0]   instr_reg [DEPTH];
    logic [PW-1:0] head_reg, fill_reg, tail_reg;
    logic [CW-1:0] drop_reg;

    logic [CW-1:0] occ_cnt, pend_cnt;
    logic [CW:0]   credit_sum, flush_sum;
    logic [CW-1:0] drop_flush;
    logic          accept, resp_fill, resp_drop, pop;

    always_comb begin
        occ_cnt  = '0;
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (state_reg[i] != ST_EMPTY)   occ_cnt  = occ_cnt + 1'b1;
            if (state_reg[i] == ST_PENDING) pend_cnt = pend_cnt + 1'b1;
        end
    end

    // Credit counts responses still owed to us from before a flush, so the
    // bus never carries more than DEPTH reads at once.
    assign credit_sum = {1'b0, occ_cnt} + {1'b0, drop_reg};
    assign o_req_ready = !i_reset && !i_flush && i_mem_req_ready
                         && (credit_sum < (CW+1)'(DEPTH));

    assign o_mem_req_valid = i_req_valid && o_req_ready;
    assign o_mem_addr      = i_req_pc;

    assign o_instr_valid = !i_reset && !i_flush && (state_reg[head_reg] == ST_READY);
    assign o_instr       = instr_reg[head_reg];
    assign o_instr_pc    = pc_reg[head_reg];

    assign accept    = o_mem_req_valid;
    assign resp_drop = i_mem_resp_valid && (drop_reg != '0);
    assign resp_fill = i_mem_resp_valid && (drop_reg == '0)
                       && (state_reg[fill_reg] == ST_PENDING);
    assign pop       = o_instr_valid && i_instr_ready;

    // A response landing in the flush cycle is already one of the owed ones.
    assign flush_sum  = {1'b0, drop_reg} + {1'b0, pend_cnt};
    assign drop_flush = (i_mem_resp_valid && flush_sum != '0)
                        ? CW'(flush_sum - 1'b1) : CW'(flush_sum);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_reg[i] <= ST_EMPTY;
                pc_reg[i]    <= '0;
                instr_reg[i] <= '0;
            end
            head_reg <= '0;
            fill_reg <= '0;
            tail_reg <= '0;
            drop_reg <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_reg[i] <= ST_EMPTY;
            end
            head_reg <= '0;
            fill_reg <= '0;
            tail_reg <= '0;
            drop_reg <= drop_flush;
        end else begin
            // Tail, fill and head always address distinct entries when active.
            if (accept) begin
                state_reg[tail_reg] <= ST_PENDING;
                pc_reg[tail_reg]    <= i_req_pc;
                tail_reg            <= tail_reg + 1'b1;
            end
            if (resp_fill) begin
                state_reg[fill_reg] <= ST_READY;
                instr_reg[fill_reg] <= i_mem_resp_data;
                fill_reg            <= fill_reg + 1'b1;
            end
            if (resp_drop) begin
                drop_reg <= drop_reg - 1'b1;
            end
            if (pop) begin
                state_reg[head_reg] <= ST_EMPTY;
                head_reg            <= head_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv_ifetch_buf.sv
// Directed bench for rv_ifetch_buf: single fetch, fill, flush/drop, wrap, reset.
module tb_rv_ifetch_buf;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic [31:2] i_req_pc;
    logic        o_req_ready;
    logic        o_mem_req_valid;
    logic [31:2] o_mem_addr;
    logic        i_mem_req_ready;
    logic        i_mem_resp_valid;
    logic [31:0] i_mem_resp_data;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:2] o_instr_pc;
    logic        i_instr_ready;
    logic        i_flush;

    int total = 0;
    int bad   = 0;

    rv_ifetch_buf #(.DEPTH(4)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_req_valid      (i_req_valid),
        .i_req_pc         (i_req_pc),
        .o_req_ready      (o_req_ready),
        .o_mem_req_valid  (o_mem_req_valid),
        .o_mem_addr       (o_mem_addr),
        .i_mem_req_ready  (i_mem_req_ready),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_resp_data  (i_mem_resp_data),
        .o_instr_valid    (o_instr_valid),
        .o_instr          (o_instr),
        .o_instr_pc       (o_instr_pc),
        .i_instr_ready    (i_instr_ready),
        .i_flush          (i_flush)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ins, input logic [29:0] pc);
        chk({tag, "_v"}, {31'd0, o_instr_valid}, 32'd1);
        chk({tag, "_i"}, o_instr, ins);
        chk({tag, "_pc"}, {2'b00, o_instr_pc}, {2'b00, pc});
    endtask

    initial begin
        int nout;
        int exp_idx;
        int resp_idx;
        logic prev_acc;

        i_reset = 1'b1; i_req_valid = 1'b1; i_req_pc = 30'h10;
        i_mem_req_ready = 1'b1; i_mem_resp_valid = 1'b0; i_mem_resp_data = '0;
        i_instr_ready = 1'b0; i_flush = 1'b0;
        tick(); #1;
        chk("rst_ivalid", {31'd0, o_instr_valid}, 32'd0);
        chk("rst_mvalid", {31'd0, o_mem_req_valid}, 32'd0);
        i_reset = 1'b0; i_req_valid = 1'b0;
        tick();

        // Single fetch
        i_mem_req_ready = 1'b0; #1;
        chk("busy_ready", {31'd0, o_req_ready}, 32'd0);
        i_mem_req_ready = 1'b1;
        i_req_valid = 1'b1; i_req_pc = 30'h40; #1;
        chk("f1_ready", {31'd0, o_req_ready}, 32'd1);
        chk("f1_mvalid", {31'd0, o_mem_req_valid}, 32'd1);
        chk("f1_addr", {2'b00, o_mem_addr}, 32'h40);
        tick();
        i_req_valid = 1'b0;
        tick();
        i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'h00000013; #1;
        chk("f1_nobypass", {31'd0, o_instr_valid}, 32'd0);
        tick();
        i_mem_resp_valid = 1'b0; #1;
        chk_out("f1", 32'h00000013, 30'h40);
        i_instr_ready = 1'b1;
        tick();
        i_instr_ready = 1'b0; #1;
        chk("f1_popped", {31'd0, o_instr_valid}, 32'd0);

        // Fill to full, responses withheld
        for (int k = 0; k < 4; k++) begin
            i_req_valid = 1'b1; i_req_pc = 30'h50 + 30'(k); #1;
            chk("fill_ready", {31'd0, o_req_ready}, 32'd1);
            tick();
        end
        i_req_pc = 30'h54; #1;
        chk("full_ready", {31'd0, o_req_ready}, 32'd0);
        chk("full_mvalid", {31'd0, o_mem_req_valid}, 32'd0);
        i_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hA0 + 32'(k);
            tick();
        end
        i_mem_resp_valid = 1'b0; #1;
        chk_out("full_head", 32'hA0, 30'h50);
        chk("full_ready2", {31'd0, o_req_ready}, 32'd0);
        i_instr_ready = 1'b1; #1;
        chk("pop_noready", {31'd0, o_req_ready}, 32'd0);
        tick();
        i_instr_ready = 1'b0; #1;
        chk("pop_ready", {31'd0, o_req_ready}, 32'd1);
        i_instr_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk_out("drain", 32'hA0 + 32'(k), 30'h50 + 30'(k));
            tick();
        end
        i_instr_ready = 1'b0; #1;
        chk("drain_empty", {31'd0, o_instr_valid}, 32'd0);

        // Flush with 2 pending
        i_req_valid = 1'b1; i_req_pc = 30'h60; tick();
        i_req_pc = 30'h61; tick();
        i_req_valid = 1'b0; i_flush = 1'b1; #1;
        chk("flush_ready", {31'd0, o_req_ready}, 32'd0);
        tick();
        i_flush = 1'b0;
        i_req_valid = 1'b1; i_req_pc = 30'h80; tick();
        i_req_valid = 1'b0;
        i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hAAAA0001; tick();
        i_mem_resp_data = 32'hBBBB0002; tick();
        #1;
        chk("fl_dropped", {31'd0, o_instr_valid}, 32'd0);
        i_mem_resp_data = 32'hCCCC0003; tick();
        i_mem_resp_valid = 1'b0; #1;
        chk_out("fl_c", 32'hCCCC0003, 30'h80);
        i_instr_ready = 1'b1; tick();
        i_instr_ready = 1'b0;

        // Flush coincident with a response, 3 pending -> 2 owed
        i_req_valid = 1'b1; i_req_pc = 30'h90; tick();
        i_req_pc = 30'h91; tick();
        i_req_pc = 30'h92; tick();
        i_req_valid = 1'b0;
        i_flush = 1'b1; i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hDEAD0000;
        tick();
        i_flush = 1'b0; i_mem_resp_valid = 1'b0;
        i_req_valid = 1'b1; i_req_pc = 30'hA0; #1;
        chk("fr_ready0", {31'd0, o_req_ready}, 32'd1);
        tick();
        i_req_pc = 30'hA1; #1;
        chk("fr_ready1", {31'd0, o_req_ready}, 32'd1);
        tick();
        i_req_pc = 30'hA2; #1;
        chk("fr_credit", {31'd0, o_req_ready}, 32'd0);
        i_req_valid = 1'b0;
        i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hDEAD0001; tick();
        #1;
        chk("fr_ready2", {31'd0, o_req_ready}, 32'd1);
        i_mem_resp_data = 32'hDEAD0002; tick();
        #1;
        chk("fr_dropped", {31'd0, o_instr_valid}, 32'd0);
        i_mem_resp_data = 32'hD0; tick();
        i_mem_resp_data = 32'hD1; tick();
        i_mem_resp_valid = 1'b0; #1;
        chk_out("fr_d0", 32'hD0, 30'hA0);
        i_instr_ready = 1'b1; tick(); #1;
        chk_out("fr_d1", 32'hD1, 30'hA1);
        tick();
        i_instr_ready = 1'b0;

        // Wrap: 10 back-to-back fetches, single-cycle response latency
        nout = 0; exp_idx = 0; resp_idx = 0; prev_acc = 1'b0;
        i_instr_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            i_req_valid = (c < 10);
            i_req_pc = 30'h100 + 30'(c);
            i_mem_resp_valid = prev_acc;
            i_mem_resp_data = 32'hC0000000 + 32'(resp_idx);
            #1;
            if (c < 10) chk("wr_ready", {31'd0, o_req_ready}, 32'd1);
            if (o_instr_valid) begin
                chk("wr_instr", o_instr, 32'hC0000000 + 32'(exp_idx));
                chk("wr_pc", {2'b00, o_instr_pc}, 32'h100 + 32'(exp_idx));
                exp_idx++;
                nout++;
            end
            if (prev_acc) resp_idx++;
            prev_acc = i_req_valid && o_req_ready;
            tick();
        end
        i_req_valid = 1'b0; i_mem_resp_valid = 1'b0; i_instr_ready = 1'b0;
        chk("wr_count", 32'(nout), 32'd10);

        // Reset mid-stream with one READY and 2 PENDING
        i_req_valid = 1'b1; i_req_pc = 30'h180; tick();
        i_req_pc = 30'h181; i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hE0; tick();
        i_req_pc = 30'h182; i_mem_resp_valid = 1'b0; tick();
        #1;
        chk("rm_before", {31'd0, o_instr_valid}, 32'd1);
        i_reset = 1'b1; #1;
        chk("rm_ivalid", {31'd0, o_instr_valid}, 32'd0);
        chk("rm_mvalid", {31'd0, o_mem_req_valid}, 32'd0);
        tick();
        i_reset = 1'b0; i_req_valid = 1'b0;
        i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hBAD00001; tick();
        i_mem_resp_data = 32'hBAD00002; tick();
        i_mem_resp_valid = 1'b0; #1;
        chk("rm_stray", {31'd0, o_instr_valid}, 32'd0);
        chk("rm_ready", {31'd0, o_req_ready}, 32'd1);
        i_req_valid = 1'b1; i_req_pc = 30'h1C0; tick();
        i_req_valid = 1'b0;
        i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hF00D; tick();
        i_mem_resp_valid = 1'b0; #1;
        chk_out("rm_fresh", 32'hF00D, 30'h1C0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv_ifetch_buf.md
RV_IFETCH_BUF -- requirements
Module: rv_ifetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, power of two >= 2: number of instruction entries and maximum outstanding memory requests.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_req_valid  input  1  fetch stage presents a PC.
REQ-005 SHALL have port i_req_pc  input  [31:2]  word address of the instruction to fetch.
REQ-006 SHALL have port o_req_ready  output  1  request accepted this cycle when high together with i_req_valid.
REQ-007 SHALL have ports o_mem_req_valid (output, 1) and o_mem_addr (output, [31:2]): instruction-bus request.
REQ-008 SHALL have port i_mem_req_ready  input  1  bus accepts the request.
REQ-009 SHALL have ports i_mem_resp_valid (input, 1) and i_mem_resp_data (input, [31:0]): in-order read responses.
REQ-010 SHALL have ports o_instr_valid (output, 1), o_instr (output, [31:0]) and o_instr_pc (output, [31:2]): to decode.
REQ-011 SHALL have port i_instr_ready  input  1  decode consumes the head entry.
REQ-012 SHALL have port i_flush  input  1  redirect; discard all queued and in-flight fetches.

Function
REQ-013 SHALL keep a circular buffer of DEPTH entries {state, pc, instr}, state in {EMPTY, PENDING, READY}, with head, fill and tail pointers.
REQ-014 SHALL accept a request when credit = occupied entries + drop_cnt < DEPTH, i_mem_req_ready=1 and i_flush=0; o_req_ready SHALL equal exactly that condition.
REQ-015 SHALL drive o_mem_req_valid = i_req_valid & o_req_ready and o_mem_addr = i_req_pc combinationally (zero-cycle pass-through).
REQ-016 On acceptance, SHALL write entry[tail] <= {PENDING, i_req_pc} and advance tail modulo DEPTH.
REQ-017 On i_mem_resp_valid with drop_cnt = 0, SHALL write entry[fill] <= {READY, i_mem_resp_data} and advance fill; data becomes visible on o_instr one cycle after the response (no bypass).
REQ-018 On i_mem_resp_valid with drop_cnt > 0, SHALL discard the data and decrement drop_cnt.
REQ-019 A response with no PENDING entry and drop_cnt = 0 SHALL be ignored without state change.
REQ-020 o_instr_valid SHALL be 1 iff entry[head] is READY and i_flush=0; o_instr/o_instr_pc SHALL show entry[head].
REQ-021 On o_instr_valid & i_instr_ready, SHALL mark entry[head] EMPTY and advance head.
REQ-022 Accept, response fill and pop in the same cycle SHALL all take effect; full-buffer pop SHALL NOT free credit for same-cycle acceptance (credit uses registered state).
REQ-023 On i_flush, SHALL set all entries EMPTY, all pointers to 0, and drop_cnt <= drop_cnt + PENDING count - (i_mem_resp_valid ? 1 : 0); flush overrides accept, fill and pop in that cycle.
REQ-024 drop_cnt SHALL be $clog2(DEPTH)+1 bits and never exceed DEPTH.
REQ-025 Pointers SHALL wrap modulo DEPTH; order of o_instr_pc SHALL equal order of accepted i_req_pc.

Reset
REQ-026 i_reset SHALL asynchronously clear all entries to EMPTY, pointers to 0 and drop_cnt to 0.
REQ-027 During and after reset, o_instr_valid=0 and o_mem_req_valid=0; o_req_ready follows i_mem_req_ready once reset is released.
REQ-028 In-flight responses arriving after a mid-operation reset SHALL be handled per REQ-019 (ignored).

Structure
REQ-029 Entry-state enum (EMPTY/PENDING/READY) and default DEPTH constant SHALL live in the shared rv_pkg package.
REQ-030 SHALL be a single module with no sub-modules; the buffer is flops, not inferred RAM.

Verification
REQ-031 Single fetch: req pc=0x100 (word 0x40), resp 0x00000013 two cycles later -> o_instr_valid next cycle, o_instr=0x00000013, o_instr_pc=0x40.
REQ-032 Fill: 4 requests, responses withheld, i_instr_ready=0 -> o_req_ready=0 after 4th; 4 responses -> 4 entries READY in request order; pop one -> o_req_ready=1 next cycle.
REQ-033 Flush with 2 PENDING: then request pc=0x200 and 3 responses A,B,C -> A and B dropped, o_instr=C with o_instr_pc=0x80.
REQ-034 Flush coincident with a response while 3 PENDING -> drop_cnt=2; that response and the next 2 discarded.
REQ-035 Wrap: stream 10 back-to-back sequential PCs with single-cycle response latency and i_instr_ready=1 -> 10 outputs, in-order, no loss or duplication.
REQ-036 Reset asserted mid-stream with 2 PENDING -> outputs deasserted immediately; stray responses after release ignored, o_instr_valid stays 0.
